// File: rtl/rf_wb_queue.sv
// Write-back queue in front of the 64x16 register-file write port.
// Buffers ALU and load results in program order, drains one write per cycle,
// and provides a two-port bypass lookup over all queued entries.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_vld,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    input  logic                     ld_vld,
    input  logic [AW-1:0]            ld_addr,
    input  logic [DW-1:0]            ld_data,
    output logic                     stall,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    input  logic [AW-1:0]            byp_addr0,
    input  logic [AW-1:0]            byp_addr1,
    output logic                     byp_hit0,
    output logic                     byp_hit1,
    output logic [DW-1:0]            byp_data0,
    output logic [DW-1:0]            byp_data1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_ld_push;
    logic          w_alu_push;
    logic          w_pop;
    logic [PW-1:0] w_alu_slot;

    // Stall on registered occupancy only, so two pushes always fit.
    assign stall = (r_count > CW'(DEPTH - 2));
    assign count = r_count;

    // r0 is never written, so pushes to it are dropped before taking a slot.
    assign w_ld_push  = ld_vld  && (ld_addr  != '0) && !stall;
    assign w_alu_push = alu_vld && (alu_addr != '0) && !stall;
    assign w_pop      = (r_count != '0);
    // The load result is older, so it takes the first free slot.
    assign w_alu_slot = r_tail + PW'(w_ld_push);

    assign rf_we    = w_pop;
    assign rf_waddr = r_addr[r_head];
    assign rf_wdata = r_data[r_head];

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            if (w_ld_push)  r_vld[r_tail]     <= 1'b1;
            if (w_alu_push) r_vld[w_alu_slot] <= 1'b1;
            r_tail  <= r_tail + PW'(w_ld_push) + PW'(w_alu_push);
            r_count <= r_count + CW'(w_ld_push) + CW'(w_alu_push) - CW'(w_pop);
        end
    end

    // Payload storage; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_ld_push) begin
            r_addr[r_tail] <= ld_addr;
            r_data[r_tail] <= ld_data;
        end
        if (w_alu_push) begin
            r_addr[w_alu_slot] <= alu_addr;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    // Bypass: scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        byp_hit0  = 1'b0;
        byp_hit1  = 1'b0;
        byp_data0 = '0;
        byp_data1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[r_head + PW'(i)] && (byp_addr0 != '0) &&
                (r_addr[r_head + PW'(i)] == byp_addr0)) begin
                byp_hit0  = 1'b1;
                byp_data0 = r_data[r_head + PW'(i)];
            end
            if (r_vld[r_head + PW'(i)] && (byp_addr1 != '0) &&
                (r_addr[r_head + PW'(i)] == byp_addr1)) begin
                byp_hit1  = 1'b1;
                byp_data1 = r_data[r_head + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: accepted pushes queue expected writes,
// a negedge monitor checks every register-file write against them.
module tb_rf_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_vld, ld_vld;
    logic [5:0]  alu_addr, ld_addr;
    logic [15:0] alu_data, ld_data;
    logic        stall, rf_we;
    logic [5:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [5:0]  byp_addr0, byp_addr1;
    logic        byp_hit0, byp_hit1;
    logic [15:0] byp_data0, byp_data1;
    logic [2:0]  count;

    int tests  = 0;
    int fails  = 0;
    logic [21:0] sb[$];

    rf_wb_queue #(.DEPTH(4), .AW(6), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_vld(alu_vld), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_addr0(byp_addr0), .byp_addr1(byp_addr1),
        .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
        .byp_data0(byp_data0), .byp_data1(byp_data1),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write seen by the register file must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                logic [21:0] e;
                e = sb.pop_front();
                if ({rf_waddr, rf_wdata} != e) begin
                    fails++;
                    $display("FAIL drain_order: got r%0d=0x%0h expected r%0d=0x%0h",
                             rf_waddr, rf_wdata, e[21:16], e[15:0]);
                end
            end
        end
    end

    // One cycle of stimulus; called just after a rising edge, returns after the next.
    task automatic cyc(input logic lv, input logic [5:0] la, input logic [15:0] ld,
                       input logic av, input logic [5:0] aa, input logic [15:0] ad,
                       output logic acc);
        ld_vld = lv; ld_addr = la; ld_data = ld;
        alu_vld = av; alu_addr = aa; alu_data = ad;
        #1;
        acc = !stall;
        if (acc) begin
            if (lv && la != 0) sb.push_back({la, ld});
            if (av && aa != 0) sb.push_back({aa, ad});
        end
        @(posedge clk); #1;
        ld_vld = 1'b0; alu_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string name);
        int budget = 40;
        while (count != 0 && budget > 0) begin @(posedge clk); #1; budget--; end
        chk(name, int'(count == 0 && sb.size() == 0), 1);
    endtask

    logic acc;

    initial begin
        rst_n = 1'b0;
        alu_vld = 0; alu_addr = 0; alu_data = 0;
        ld_vld = 0; ld_addr = 0; ld_data = 0;
        byp_addr0 = 0; byp_addr1 = 0;
        #2;
        chk("reset_count", int'(count), 0);
        chk("reset_we", int'(rf_we), 0);
        chk("reset_stall", int'(stall), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);

        // 1) reset while three entries are queued
        cyc(1, 6'd7, 16'h7007, 1, 6'd8, 16'h8008, acc);
        cyc(1, 6'd9, 16'h9009, 1, 6'd11, 16'hB00B, acc);
        chk("t1_count3", int'(count), 3);
        byp_addr0 = 6'd9; byp_addr1 = 6'd11; #1;
        chk("t1_hit_pre", int'(byp_hit0 && byp_hit1), 1);
        rst_n = 1'b0; #1;
        chk("t1_rst_count", int'(count), 0);
        chk("t1_rst_we", int'(rf_we), 0);
        chk("t1_rst_hit", int'({byp_hit0, byp_hit1}), 0);
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("t1_no_writes", int'(count), 0);

        // 2) single ALU push, one-cycle latency to the write port
        cyc(0, 0, 0, 1, 6'd5, 16'h1234, acc);
        chk("t2_we", int'(rf_we), 1);
        chk("t2_waddr", int'(rf_waddr), 5);
        chk("t2_wdata", int'(rf_wdata), 16'h1234);
        byp_addr0 = 6'd5; #1;
        chk("t2_byp", int'({byp_hit0, byp_data0}), int'({1'b1, 16'h1234}));
        idle(1);
        chk("t2_count0", int'(count), 0);

        // 3) load and ALU to the same register in one cycle
        cyc(1, 6'd3, 16'hAAAA, 1, 6'd3, 16'hBBBB, acc);
        byp_addr0 = 6'd3; #1;
        chk("t3_count2", int'(count), 2);
        chk("t3_byp_both", int'({byp_hit0, byp_data0}), int'({1'b1, 16'hBBBB}));
        idle(1);
        chk("t3_byp_after_pop", int'({byp_hit0, byp_data0}), int'({1'b1, 16'hBBBB}));
        idle(1);
        chk("t3_byp_empty", int'({byp_hit0, byp_data0}), 0);

        // 4) push to r0 is dropped
        cyc(0, 0, 0, 1, 6'd0, 16'hFFFF, acc);
        byp_addr0 = 6'd0; #1;
        chk("t4_count", int'(count), 0);
        chk("t4_we", int'(rf_we), 0);
        chk("t4_byp0", int'(byp_hit0), 0);

        // 5) two pushes per cycle until stall, held inputs re-presented
        for (int i = 0; i < 3; i++) begin
            int budget = 10;
            acc = 1'b0;
            while (!acc && budget > 0) begin
                if (i == 2 && budget == 10) chk("t5_stall", int'(stall), 1);
                cyc(1, 6'(10 + 2*i), 16'(16'h5000 + 2*i),
                    1, 6'(11 + 2*i), 16'(16'h5001 + 2*i), acc);
                budget--;
            end
            chk("t5_accepted", int'(acc), 1);
        end
        wait_drain("t5_drained");

        // 6) ten single pushes r1..r10 interleaved with drain; pointers wrap
        byp_addr1 = 6'd0;
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0, 1, 6'(i), 16'(16'h0100 + i), acc);
            chk("t6_accepted", int'(acc), 1);
            if (i % 2 == 0) idle(1);
        end
        wait_drain("t6_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
